// File: rtl/bcd_pkg.sv
// bcd_pkg: FSM encoding, digit count and seven-segment glyphs shared by the scan driver
package bcd_pkg;

    localparam int NUM_DIGITS = 4;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_GUARD,
        ST_ON
    } state_t;

    // Active-high glyphs, bit order {g,f,e,d,c,b,a}
    localparam logic [6:0] GLYPH_0    = 7'h3F;
    localparam logic [6:0] GLYPH_1    = 7'h06;
    localparam logic [6:0] GLYPH_2    = 7'h5B;
    localparam logic [6:0] GLYPH_3    = 7'h4F;
    localparam logic [6:0] GLYPH_4    = 7'h66;
    localparam logic [6:0] GLYPH_5    = 7'h6D;
    localparam logic [6:0] GLYPH_6    = 7'h7D;
    localparam logic [6:0] GLYPH_7    = 7'h07;
    localparam logic [6:0] GLYPH_8    = 7'h7F;
    localparam logic [6:0] GLYPH_9    = 7'h6F;
    localparam logic [6:0] GLYPH_DASH = 7'h40;

    // Non-decimal codes render as a dash so a bad converter word stays visible
    function automatic logic [6:0] glyph(input logic [3:0] nib);
        case (nib)
            4'd0:    glyph = GLYPH_0;
            4'd1:    glyph = GLYPH_1;
            4'd2:    glyph = GLYPH_2;
            4'd3:    glyph = GLYPH_3;
            4'd4:    glyph = GLYPH_4;
            4'd5:    glyph = GLYPH_5;
            4'd6:    glyph = GLYPH_6;
            4'd7:    glyph = GLYPH_7;
            4'd8:    glyph = GLYPH_8;
            4'd9:    glyph = GLYPH_9;
            default: glyph = GLYPH_DASH;
        endcase
    endfunction

endpackage

// File: rtl/bcd_seg_scan_seg_decode.sv
// seg_decode: one BCD nibble to active-high segments, with a blank override
module seg_decode
    import bcd_pkg::*;
(
    input  logic [3:0] nib_i,
    input  logic       blank_i,
    output logic [6:0] seg_o
);

    // Blanked digits light nothing; otherwise look the glyph up
    always_comb seg_o = blank_i ? 7'h00 : glyph(nib_i);

endmodule

// File: rtl/bcd_seg_scan.sv
// bcd_seg_scan: buffered four-digit multiplexed seven-segment scanner with guard intervals
module bcd_seg_scan
    import bcd_pkg::*;
#(
    parameter int CLK_DIV        = 50000,
    parameter int GUARD          = 16,
    parameter bit SEG_ACTIVE_LOW = 1'b1
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [15:0] bcd_i,
    input  logic        bcd_valid_i,
    input  logic        blank_lz_i,
    output logic        bcd_ready_o,
    output logic [6:0]  seg_o,
    output logic [3:0]  dig_o,
    output logic        frame_done_o,
    output logic        err_o
);

    localparam int CW = $clog2(CLK_DIV);
    localparam int IW = $clog2(NUM_DIGITS);
    localparam logic [CW-1:0] GUARD_LAST = CW'(GUARD - 1);
    localparam logic [CW-1:0] ON_LAST    = CW'(CLK_DIV - GUARD - 1);
    localparam logic [IW-1:0] IDX_LAST   = IW'(NUM_DIGITS - 1);

    state_t        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [IW-1:0] idx_q, idx_d;
    logic [15:0]   act_q, act_d, pend_q, pend_d;
    logic          act_blank_q, act_blank_d, pend_blank_q, pend_blank_d;
    logic          pend_full_q, pend_full_d;
    logic [6:0]    seg_q, seg_d;
    logic [3:0]    dig_q, dig_d;
    logic          frame_done_q, frame_done_d;
    logic          err_q, err_d;
    logic          boundary, accept;
    logic [3:0]    lz;
    logic [6:0]    dec_seg;

    // Buffer movement and scan sequencing; active only changes on a frame boundary
    always_comb begin
        boundary     = (state_q == ST_IDLE) || (state_q == ST_ON && idx_q == IDX_LAST && cnt_q == '0);
        accept       = bcd_valid_i && !pend_full_q;
        act_d        = act_q;
        act_blank_d  = act_blank_q;
        pend_d       = pend_q;
        pend_blank_d = pend_blank_q;
        pend_full_d  = pend_full_q;
        if (boundary && pend_full_q) begin
            act_d       = pend_q;
            act_blank_d = pend_blank_q;
            pend_full_d = 1'b0;
        end else if (boundary && accept) begin
            act_d       = bcd_i;
            act_blank_d = blank_lz_i;
        end else if (accept) begin
            pend_d       = bcd_i;
            pend_blank_d = blank_lz_i;
            pend_full_d  = 1'b1;
        end
        state_d = state_q;
        cnt_d   = cnt_q;
        idx_d   = idx_q;
        case (state_q)
            ST_IDLE: if (accept) begin
                state_d = ST_GUARD;
                cnt_d   = GUARD_LAST;
                idx_d   = '0;
            end
            ST_GUARD: if (cnt_q == '0) begin
                state_d = ST_ON;
                cnt_d   = ON_LAST;
            end else cnt_d = cnt_q - 1'b1;
            default: if (cnt_q == '0) begin
                state_d = ST_GUARD;
                cnt_d   = GUARD_LAST;
                idx_d   = idx_q + 1'b1;
            end else cnt_d = cnt_q - 1'b1;
        endcase
    end

    // Leading-zero chain: digit n is a leading zero if it and every higher nibble are zero
    always_comb begin
        lz[3] = act_d[15:12] == 4'd0;
        lz[2] = lz[3] && act_d[11:8] == 4'd0;
        lz[1] = lz[2] && act_d[7:4] == 4'd0;
        lz[0] = 1'b0;
    end

    seg_decode u_dec (
        .nib_i   (act_d[{idx_d, 2'b00} +: 4]),
        .blank_i (act_blank_d && lz[idx_d]),
        .seg_o   (dec_seg)
    );

    // Outputs are computed from next state so they register on the same edge as the FSM
    always_comb begin
        dig_d        = (state_d == ST_ON) ? (4'b0001 << idx_d) : 4'b0000;
        seg_d        = (state_d == ST_ON) ? dec_seg : 7'h00;
        frame_done_d = state_d == ST_ON && idx_d == IDX_LAST && cnt_d == '0;
        err_d        = act_d[3:0] > 4'd9 || act_d[7:4] > 4'd9 || act_d[11:8] > 4'd9 || act_d[15:12] > 4'd9;
    end

    // All state, including the output registers, clears asynchronously
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= ST_IDLE;
            cnt_q        <= '0;
            idx_q        <= '0;
            act_q        <= '0;
            act_blank_q  <= 1'b0;
            pend_q       <= '0;
            pend_blank_q <= 1'b0;
            pend_full_q  <= 1'b0;
            seg_q        <= '0;
            dig_q        <= '0;
            frame_done_q <= 1'b0;
            err_q        <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            idx_q        <= idx_d;
            act_q        <= act_d;
            act_blank_q  <= act_blank_d;
            pend_q       <= pend_d;
            pend_blank_q <= pend_blank_d;
            pend_full_q  <= pend_full_d;
            seg_q        <= seg_d;
            dig_q        <= dig_d;
            frame_done_q <= frame_done_d;
            err_q        <= err_d;
        end
    end

    assign bcd_ready_o  = !pend_full_q;
    assign seg_o        = SEG_ACTIVE_LOW ? ~seg_q : seg_q;
    assign dig_o        = dig_q;
    assign frame_done_o = frame_done_q;
    assign err_o        = err_q;

endmodule

// File: tb/tb_bcd_seg_scan.sv
// tb_bcd_seg_scan: scoreboard bench for the multiplexed seven-segment scanner
module tb_bcd_seg_scan;

    localparam int CLK_DIV = 8;
    localparam int GUARD   = 2;
    localparam int FRAME   = 4 * CLK_DIV;
    localparam logic [6:0] GLY [10] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66,
                                        7'h6D, 7'h7D, 7'h07, 7'h7F, 7'h6F};

    typedef struct {
        logic [15:0] w;
        logic        b;
        int          c;
    } ent_t;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [15:0] bcd_i = '0;
    logic        bcd_valid_i = 1'b0;
    logic        blank_lz_i = 1'b0;
    logic        bcd_ready_o;
    logic [6:0]  seg_o;
    logic [3:0]  dig_o;
    logic        frame_done_o;
    logic        err_o;

    int   n_chk = 0;
    int   n_fail = 0;
    int   cyc = 0;
    ent_t sb[$];

    bcd_seg_scan #(.CLK_DIV(CLK_DIV), .GUARD(GUARD), .SEG_ACTIVE_LOW(1'b1)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .bcd_i        (bcd_i),
        .bcd_valid_i  (bcd_valid_i),
        .blank_lz_i   (blank_lz_i),
        .bcd_ready_o  (bcd_ready_o),
        .seg_o        (seg_o),
        .dig_o        (dig_o),
        .frame_done_o (frame_done_o),
        .err_o        (err_o)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, got, exp, cyc);
        end
    endtask

    // Reference: glyph of digit d, honouring leading-zero blanking
    function automatic logic [6:0] exp_seg(input logic [15:0] w, input logic b, input int d);
        int nib;
        nib = (int'(w) >> (4 * d)) & 15;
        if (b && d > 0 && (int'(w) >> (4 * d)) == 0) return 7'h00;
        return nib > 9 ? 7'h40 : GLY[nib];
    endfunction

    function automatic logic exp_err(input logic [15:0] w);
        for (int k = 0; k < 4; k++) if (((int'(w) >> (4 * k)) & 15) > 9) return 1'b1;
        return 1'b0;
    endfunction

    // Offer a word; at_bnd holds valid back until a frame_done cycle
    task automatic offer(input logic [15:0] w, input logic b, input bit at_bnd, input int max_wait,
                         output bit ok, output int acc);
        ok = 0;
        acc = -1;
        bcd_i = w;
        blank_lz_i = b;
        for (int i = 0; i < max_wait && !ok; i++) begin
            @(negedge clk);
            bcd_valid_i = !at_bnd;
            if (rst_n && bcd_ready_o && (!at_bnd || frame_done_o)) begin
                bcd_valid_i = 1'b1;
                ok = 1;
                acc = cyc;
                sb.push_back('{w, b, cyc});
            end
        end
        @(posedge clk);
        #1 bcd_valid_i = 1'b0;
    endtask

    // Digit 0 must light exactly GUARD+1 cycles after the accept cycle
    task automatic check_latency(input int c, input logic [15:0] w, input logic b);
        logic [6:0] e;
        e = ~exp_seg(w, b, 0);
        do @(negedge clk); while (cyc < c + 2);
        check("guard_before_first_digit", dig_o, 4'b0000);
        @(negedge clk);
        check("first_digit_enable", dig_o, 4'b0001);
        check("first_digit_seg", seg_o, e);
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_seg"}, seg_o, 7'h7F);
        check({tag, "_dig"}, dig_o, 4'b0000);
        check({tag, "_frame_done"}, frame_done_o, 1'b0);
        check({tag, "_err"}, err_o, 1'b0);
        check({tag, "_ready"}, bcd_ready_o, 1'b1);
    endtask

    // Monitor: collects one frame of digit glyphs and scores it against the queued words
    logic [6:0] cap[4];
    int         on_cnt[4];
    bit         bad, cur_ok, have_prev;
    int         prev_fd;
    ent_t       cur;

    always @(negedge clk) begin
        if (!rst_n) begin
            sb.delete();
            cur_ok = 0;
            have_prev = 0;
            bad = 0;
            for (int d = 0; d < 4; d++) begin
                cap[d] = '0;
                on_cnt[d] = 0;
            end
        end else begin
            if (dig_o == 4'b0000) begin
                if (seg_o != 7'h7F) bad = 1;
            end else if ($onehot(dig_o)) begin
                for (int d = 0; d < 4; d++) if (dig_o[d]) begin
                    if (on_cnt[d] != 0 && cap[d] != ~seg_o) bad = 1;
                    cap[d] = ~seg_o;
                    on_cnt[d]++;
                end
            end else bad = 1;
            if (frame_done_o) begin
                while (sb.size() > 0 && sb[0].c <= cyc - FRAME) begin
                    cur = sb.pop_front();
                    cur_ok = 1;
                end
                check("frame_has_word", cur_ok, 1'b1);
                for (int d = 0; d < 4; d++) begin
                    check($sformatf("frame_digit%0d_seg", d), cap[d], exp_seg(cur.w, cur.b, d));
                    check($sformatf("frame_digit%0d_on_cycles", d), on_cnt[d], CLK_DIV - GUARD);
                    cap[d] = '0;
                    on_cnt[d] = 0;
                end
                check("frame_err", err_o, exp_err(cur.w));
                check("frame_no_tear_or_ghost", bad, 1'b0);
                if (have_prev) check("frame_period", cyc - prev_fd, FRAME);
                have_prev = 1;
                prev_fd = cyc;
                bad = 0;
            end
        end
    end

    initial begin
        bit ok;
        int c, v;
        logic [15:0] w;
        logic b;

        // Reset state
        repeat (3) @(posedge clk);
        #1 check_reset_outputs("reset");
        @(negedge clk) rst_n = 1'b1;
        repeat (3) @(negedge clk);
        check("idle_dig", dig_o, 4'b0000);
        check("idle_ready", bcd_ready_o, 1'b1);

        // First word, blanking on
        offer(16'h0123, 1'b1, 1'b0, 10, ok, c);
        check("accept_0123", ok, 1'b1);
        check_latency(c, 16'h0123, 1'b1);
        repeat (3 * FRAME) @(negedge clk);

        // Back-to-back words: the second stalls until a boundary, the third is refused
        for (int i = 0; i < 100 && dig_o != 4'b0010; i++) @(negedge clk);
        offer(16'h0042, 1'b0, 1'b0, 10, ok, c);
        check("accept_A", ok, 1'b1);
        check("ready_low_after_A", bcd_ready_o, 1'b0);
        offer(16'h0999, 1'b0, 1'b0, 100, ok, c);
        check("accept_B", ok, 1'b1);
        offer(16'h1111, 1'b0, 1'b0, 1, ok, c);
        check("third_word_refused", ok, 1'b0);
        check("ready_low_during_stall", bcd_ready_o, 1'b0);
        repeat (3 * FRAME) @(negedge clk);

        // All zeros with blanking: only digit 0 lights
        offer(16'h0000, 1'b1, 1'b0, 100, ok, c);
        check("accept_zero", ok, 1'b1);
        repeat (2 * FRAME) @(negedge clk);

        // Non-decimal nibble raises err_o, next word clears it
        offer(16'h00A5, 1'b0, 1'b0, 100, ok, c);
        check("accept_A5", ok, 1'b1);
        repeat (2 * FRAME) @(negedge clk);
        check("err_high_for_A5", err_o, 1'b1);
        offer(16'h0005, 1'b0, 1'b0, 100, ok, c);
        check("accept_05", ok, 1'b1);
        repeat (2 * FRAME) @(negedge clk);
        check("err_cleared", err_o, 1'b0);

        // Accept landing exactly on the boundary cycle bypasses into active
        offer(16'h4321, 1'b0, 1'b1, 100, ok, c);
        check("accept_on_boundary", ok, 1'b1);
        check_latency(c, 16'h4321, 1'b0);
        repeat (2 * FRAME) @(negedge clk);

        // Randomized words and gaps
        for (int n = 0; n < 14; n++) begin
            if ($urandom_range(0, 3) == 0) w = 16'($urandom);
            else begin
                v = $urandom_range(0, 9999);
                if ($urandom_range(0, 1) == 1) v = v % 100;
                w = 16'(((v / 1000) << 12) | (((v / 100) % 10) << 8) | (((v / 10) % 10) << 4) | (v % 10));
            end
            b = 1'($urandom_range(0, 1));
            repeat ($urandom_range(0, 40)) @(negedge clk);
            offer(w, b, 1'b0, 100, ok, c);
            check("accept_random", ok, 1'b1);
        end
        repeat (3 * FRAME) @(negedge clk);

        // Asynchronous reset during the digit-2 ON phase
        ok = 0;
        for (int i = 0; i < 100 && !ok; i++) begin
            @(negedge clk);
            ok = dig_o == 4'b0100;
        end
        check("reached_digit2", ok, 1'b1);
        #2 rst_n = 1'b0;
        #1 check_reset_outputs("async_reset");
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (4) @(negedge clk);
        check("post_reset_idle_dig", dig_o, 4'b0000);
        check("post_reset_ready", bcd_ready_o, 1'b1);
        offer(16'h0807, 1'b1, 1'b0, 10, ok, c);
        check("accept_after_reset", ok, 1'b1);
        check_latency(c, 16'h0807, 1'b1);
        repeat (3 * FRAME) @(negedge clk);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
